pcm_source_mux: RTL and testbench

- Parametrised PCM source selector for the core clock domain, the successor to the fixed 4-source, 24-bit stereo front-end mux.
- Selects one of NUM_SRC PCM streams and passes it downstream with a valid/ready handshake.
- On a source change it switches without clicks: a linear gain fade-out of the old source, then a fade-in of the new one.
- Detects loss of the active source by timeout, holds the output silent, and fades back in when the source resumes.
- All inputs are already in the `clk` domain; CDC stays in the per-source receivers.

---
 rtl/kosei_pcm_pkg.sv | 29 ++
 rtl/pcm_gain_stage.sv | 32 +++
 rtl/pcm_source_mux.sv | 219 +++++++++++++++++++++
 tb/tb_pcm_source_mux.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/kosei_pcm_pkg.sv
// Shared definitions for the PCM source selector: FSM states, gain width
// and frame slicing helper.
package kosei_pcm_pkg;

  // Fade controller states.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_SWITCH   = 2'd2,
    ST_FADE_IN  = 2'd3
  } pcm_state_e;

  // Gain must hold 0..2^RAMP_LOG2 inclusive, hence one extra bit.
  localparam int RAMP_LOG2_DEFAULT = 6;
  localparam int GAIN_W            = RAMP_LOG2_DEFAULT + 1;

  // Gain width for an arbitrary ramp length.
  function automatic int unsigned gain_width(input int unsigned ramp_log2);
    return ramp_log2 + 32'd1;
  endfunction

  // LSB position of source 'src' inside the flattened frame bus.
  function automatic int unsigned pcm_frame(input int unsigned src,
                                            input int unsigned ch,
                                            input int unsigned data_w);
    return src * ch * data_w;
  endfunction

endpackage

// File: rtl/pcm_gain_stage.sv
// CH parallel signed sample x gain multipliers followed by an arithmetic
// right shift of RAMP_LOG2 (rounds toward minus infinity).
module pcm_gain_stage #(
  parameter int DATA_W    = 24,
  parameter int RAMP_LOG2 = 6,
  parameter int CH        = 2
) (
  input  logic [CH*DATA_W-1:0] frame,
  input  logic [RAMP_LOG2:0]   gain,
  output logic [CH*DATA_W-1:0] gained
);

  localparam int PROD_W = DATA_W + RAMP_LOG2 + 2;

  // Gain is unsigned; zero-extend so the signed multiply sees a positive value.
  logic signed [PROD_W-1:0] gain_ext;
  assign gain_ext = $signed({{(PROD_W-RAMP_LOG2-1){1'b0}}, gain});

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DATA_W-1:0] sample;
    logic signed [PROD_W-1:0] prod;
    logic                     unused_bits;

    assign sample = frame[c*DATA_W +: DATA_W];
    assign prod   = PROD_W'(sample) * gain_ext;
    // Taking bits above RAMP_LOG2 of the two's complement product is the
    // arithmetic shift; gain <= unity keeps the result inside DATA_W.
    assign gained[c*DATA_W +: DATA_W] = prod[RAMP_LOG2 +: DATA_W];
    assign unused_bits = ^{prod[PROD_W-1 -: 2], prod[RAMP_LOG2-1:0]};
  end

endmodule

// File: rtl/pcm_source_mux.sv
// PCM source selector with click-free linear cross-fade on source change,
// loss-of-source timeout and a single-entry valid/ready output register.
module pcm_source_mux #(
  parameter int NUM_SRC      = 4,
  parameter int SEL_W        = $clog2(NUM_SRC),
  parameter int DATA_W       = 24,
  parameter int CH           = 2,
  parameter int RAMP_LOG2    = 6,
  parameter int LOSS_TIMEOUT = 4096,
  parameter int DEFAULT_SEL  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SEL_W-1:0]             input_sel,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*CH*DATA_W-1:0] src_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH*DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]             active_sel,
  output logic                         src_lost,
  output logic                         switching,
  output logic                         overrun,
  input  logic                         ovr_clr
);

  import kosei_pcm_pkg::*;

  localparam int FRAME_W = CH * DATA_W;
  localparam int GW      = gain_width(RAMP_LOG2);
  localparam int CNT_W   = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [GW-1:0]    GAIN_UNITY = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [GW-1:0]    GAIN_ZERO  = {GW{1'b0}};
  localparam logic [GW-1:0]    GAIN_ONE   = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LOSS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(LOSS_TIMEOUT);
  localparam logic [SEL_W-1:0] SEL_RST    = SEL_W'(DEFAULT_SEL);

  pcm_state_e         state;
  pcm_state_e         state_next;
  logic [GW-1:0]      gain;
  logic [GW-1:0]      gain_nxt;
  logic [GW-1:0]      gain_step;
  logic [SEL_W-1:0]   target;
  logic [CNT_W-1:0]   loss_cnt;
  logic [FRAME_W-1:0] act_frame;
  logic [FRAME_W-1:0] gained_frame;
  logic               sel_legal;
  logic               act_valid;
  logic               accept;
  logic               can_load;
  logic               load;
  logic               drop;
  logic               lost_set;

  assign sel_legal = (32'(input_sel) < 32'(NUM_SRC));
  assign act_valid = src_valid[active_sel];
  assign act_frame = src_data[pcm_frame(32'(active_sel), CH, DATA_W) +: FRAME_W];

  // Frames are taken only from a live active source outside the SWITCH cycle.
  assign accept   = act_valid && !src_lost && (state != ST_SWITCH);
  assign can_load = !out_valid || out_ready;
  assign load     = accept && can_load;
  assign drop     = accept && !can_load;
  // Counter is about to reach the timeout without a frame from the source.
  assign lost_set = !act_valid && !src_lost && (loss_cnt == CNT_LAST);

  pcm_gain_stage #(
    .DATA_W    (DATA_W),
    .RAMP_LOG2 (RAMP_LOG2),
    .CH        (CH)
  ) u_gain (
    .frame  (act_frame),
    .gain   (gain_step),
    .gained (gained_frame)
  );

  // Capture the requested source whenever the request is legal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= SEL_RST;
    end else if (sel_legal) begin
      target <= input_sel;
    end
  end

  // The routed source changes only in the single SWITCH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_sel <= SEL_RST;
    end else if (state == ST_SWITCH) begin
      active_sel <= target;
    end
  end

  // FSM state, gain and registered switching flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FADE_IN;
      gain      <= GAIN_ZERO;
      switching <= 1'b1;
    end else begin
      state     <= state_next;
      gain      <= gain_nxt;
      switching <= (state_next != ST_RUN);
    end
  end

  // Gain applied to the frame accepted this cycle (saturates at both ends).
  always_comb begin
    gain_step = gain;
    case (state)
      ST_RUN: begin
        gain_step = GAIN_UNITY;
      end
      ST_FADE_OUT: begin
        if (gain == GAIN_ZERO) gain_step = GAIN_ZERO;
        else                   gain_step = gain - GAIN_ONE;
      end
      ST_FADE_IN: begin
        if (gain == GAIN_UNITY) gain_step = GAIN_UNITY;
        else                    gain_step = gain + GAIN_ONE;
      end
      default: begin
        gain_step = gain;
      end
    endcase
  end

  // Next state and next gain.
  always_comb begin
    state_next = state;
    if (load) gain_nxt = gain_step;
    else      gain_nxt = gain;
    case (state)
      ST_RUN: begin
        if (lost_set) begin
          state_next = ST_FADE_IN;
          gain_nxt   = GAIN_ZERO;
        end else if (target != active_sel) begin
          state_next = ST_FADE_OUT;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_FADE_OUT: begin
        if (src_lost) begin
          state_next = ST_SWITCH;
        end else if (target == active_sel) begin
          state_next = ST_FADE_IN;
        end else if ((gain == GAIN_ZERO) || (load && (gain_step == GAIN_ZERO))) begin
          state_next = ST_SWITCH;
        end else begin
          state_next = ST_FADE_OUT;
        end
      end
      ST_SWITCH: begin
        state_next = ST_FADE_IN;
        gain_nxt   = GAIN_ZERO;
      end
      ST_FADE_IN: begin
        if (lost_set) begin
          state_next = ST_FADE_IN;
          gain_nxt   = GAIN_ZERO;
        end else if (target != active_sel) begin
          state_next = ST_FADE_OUT;
        end else if (load && (gain_step == GAIN_UNITY)) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_FADE_IN;
        end
      end
      default: begin
        state_next = ST_FADE_IN;
        gain_nxt   = GAIN_ZERO;
      end
    endcase
  end

  // Loss timeout: saturating counter cleared by the active source's frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= {CNT_W{1'b0}};
      src_lost <= 1'b0;
    end else if ((state == ST_SWITCH) || act_valid) begin
      loss_cnt <= {CNT_W{1'b0}};
      src_lost <= 1'b0;
    end else begin
      if (loss_cnt != CNT_MAX) loss_cnt <= loss_cnt + CNT_W'(1);
      if (lost_set)            src_lost <= 1'b1;
    end
  end

  // Output register: holds until accepted, may reload in the accepting cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {FRAME_W{1'b0}};
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= gained_frame;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcm_source_mux.sv
// Directed scenarios with random sample values; expected outputs come from
// the fade gain sequence and a floor-division scaling model.
module tb_pcm_source_mux;

  localparam int NUM_SRC      = 3;
  localparam int SEL_W        = 2;
  localparam int DATA_W       = 24;
  localparam int CH           = 2;
  localparam int RAMP_LOG2    = 2;
  localparam int LOSS_TIMEOUT = 16;
  localparam int FRAME_W      = CH * DATA_W;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [SEL_W-1:0]             input_sel;
  logic [NUM_SRC-1:0]           src_valid;
  logic [NUM_SRC*FRAME_W-1:0]   src_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [FRAME_W-1:0]           out_data;
  logic [SEL_W-1:0]             active_sel;
  logic                         src_lost;
  logic                         switching;
  logic                         overrun;
  logic                         ovr_clr;

  int n_cmp = 0;
  int n_bad = 0;

  pcm_source_mux #(
    .NUM_SRC      (NUM_SRC),
    .SEL_W        (SEL_W),
    .DATA_W       (DATA_W),
    .CH           (CH),
    .RAMP_LOG2    (RAMP_LOG2),
    .LOSS_TIMEOUT (LOSS_TIMEOUT),
    .DEFAULT_SEL  (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .input_sel  (input_sel),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .active_sel (active_sel),
    .src_lost   (src_lost),
    .switching  (switching),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sample * g / 2^RAMP_LOG2 rounded toward minus infinity.
  function automatic logic [23:0] scale(input logic [23:0] s, input int g);
    longint v, p, q, den;
    den = longint'(1) << RAMP_LOG2;
    v = longint'($signed(s));
    p = v * longint'(g);
    if (p >= 0) q = p / den;
    else        q = -((-p + den - 1) / den);
    return q[23:0];
  endfunction

  function automatic logic [23:0] rnd();
    logic [31:0] r;
    r = $urandom();
    return r[23:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input logic [23:0] c0, input logic [23:0] c1);
    src_valid = '0;
    src_valid[s] = 1'b1;
    src_data[s*FRAME_W +: FRAME_W] = {c1, c0};
    tick();
    src_valid = '0;
  endtask

  task automatic expect_frame(input string tag, input int g,
                              input logic [23:0] c0, input logic [23:0] c1);
    check(tag, {15'd0, out_valid, out_data}, {15'd0, 1'b1, scale(c1, g), scale(c0, g)});
  endtask

  task automatic send_exp(input string tag, input int s, input int g,
                          input logic [23:0] c0, input logic [23:0] c1);
    send(s, c0, c1);
    expect_frame(tag, g, c0, c1);
  endtask

  initial begin
    logic [23:0] a0, a1, b0, b1;
    rst_n     = 1'b0;
    input_sel = 2'd0;
    src_valid = '0;
    src_data  = '0;
    out_ready = 1'b1;
    ovr_clr   = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_out", {15'd0, out_valid, out_data}, 64'd0);
    check("rst_flags", {60'd0, active_sel, src_lost, switching},
          {60'd0, 2'd0, 1'b0, 1'b1});
    check("rst_ovr", {63'd0, overrun}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1. First frames fade in
    for (int g = 1; g <= 4; g++) begin
      if (g == 4) check("sw_before_run", {63'd0, switching}, 64'd1);
      send_exp("fade_in_first", 0, g, 24'h100000, 24'h100000);
    end
    check("sw_run", {63'd0, switching}, 64'd0);
    send_exp("run_unity", 0, 4, 24'h100000, 24'h100000);
    // Back-to-back random frames at unity: bit-exact passthrough
    for (int i = 0; i < 8; i++) begin
      a0 = rnd(); a1 = rnd();
      send(0, a0, a1);
      check("run_pass", {15'd0, out_valid, out_data}, {15'd0, 1'b1, a1, a0});
    end

    // 2. Switch 0 -> 2
    input_sel = 2'd2;
    tick(); tick();
    for (int g = 3; g >= 0; g--) begin
      a1 = rnd();
      send_exp("sw_fade_out", 0, g, 24'h100000, a1);
      check("sw_sel_old", {62'd0, active_sel}, 64'd0);
    end
    tick();
    check("sw_sel_new", {61'd0, active_sel, switching}, {61'd0, 2'd2, 1'b1});
    send(0, rnd(), rnd());
    check("inactive_ignored", {63'd0, out_valid}, 64'd0);
    for (int g = 1; g <= 4; g++) begin
      a1 = rnd();
      send_exp("sw_fade_in", 2, g, 24'hF00000, a1);
    end
    check("sw_run2", {63'd0, switching}, 64'd0);

    // Back to source 0 with random samples
    input_sel = 2'd0;
    tick(); tick();
    for (int g = 3; g >= 0; g--) send_exp("back_out", 2, g, rnd(), rnd());
    tick();
    for (int g = 1; g <= 4; g++) send_exp("back_in", 0, g, rnd(), rnd());
    check("back_sel", {61'd0, active_sel, switching}, {61'd0, 2'd0, 1'b0});

    // 3. Reversal
    input_sel = 2'd1;
    tick(); tick();
    send_exp("rev_out3", 0, 3, rnd(), rnd());
    send_exp("rev_out2", 0, 2, rnd(), rnd());
    input_sel = 2'd0;
    tick(); tick();
    send_exp("rev_in3", 0, 3, rnd(), rnd());
    check("rev_sel", {61'd0, active_sel, switching}, {61'd0, 2'd0, 1'b1});
    send_exp("rev_in4", 0, 4, rnd(), rnd());
    check("rev_run", {61'd0, active_sel, switching}, {61'd0, 2'd0, 1'b0});

    // 4. Loss of source 0
    for (int i = 0; i < LOSS_TIMEOUT - 1; i++) tick();
    check("loss_not_yet", {63'd0, src_lost}, 64'd0);
    tick();
    check("loss_set", {61'd0, src_lost, out_valid, switching}, {61'd0, 1'b1, 1'b0, 1'b1});
    tick(); tick();
    check("loss_silent", {63'd0, out_valid}, 64'd0);
    send(0, rnd(), rnd());
    check("loss_clear", {63'd0, src_lost}, 64'd0);
    for (int g = 1; g <= 4; g++) send_exp("loss_fade_in", 0, g, rnd(), rnd());
    check("loss_run", {63'd0, switching}, 64'd0);

    // 5. Backpressure during a fade-out to source 1
    input_sel = 2'd1;
    tick(); tick();
    out_ready = 1'b0;
    a0 = rnd(); a1 = rnd();
    send_exp("bp_first", 0, 3, a0, a1);
    check("bp_no_ovr", {63'd0, overrun}, 64'd0);
    b0 = rnd(); b1 = rnd();
    send_exp("bp_held", 0, 3, a0, a1);
    check("bp_ovr_set", {63'd0, overrun}, 64'd1);
    out_ready = 1'b1;
    tick();
    check("bp_accepted", {63'd0, out_valid}, 64'd0);
    send_exp("bp_no_step", 0, 2, b0, b1);
    check("bp_ovr_sticky", {63'd0, overrun}, 64'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("bp_ovr_clr", {63'd0, overrun}, 64'd0);
    send_exp("bp_out1", 0, 1, rnd(), rnd());
    send_exp("bp_out0", 0, 0, rnd(), rnd());
    tick();
    check("bp_sel1", {62'd0, active_sel}, 64'd1);

    // 6. Rounding at gain 1, then illegal select
    send(1, 24'h000001, 24'hFFFFFF);
    check("round", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 24'hFFFFFF, 24'h000000});
    for (int g = 2; g <= 4; g++) send_exp("fade_in_src1", 1, g, rnd(), rnd());
    input_sel = 2'd3;
    tick(); tick(); tick();
    check("illegal_sel", {61'd0, active_sel, switching}, {61'd0, 2'd1, 1'b0});
    send_exp("illegal_pass", 1, 4, rnd(), rnd());

    // Reset in the middle of a fade
    input_sel = 2'd0;
    tick(); tick();
    send_exp("pre_rst_out", 1, 3, rnd(), rnd());
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst", {12'd0, out_valid, out_data, active_sel, src_lost, switching},
          {12'd0, 1'b0, 48'd0, 2'd0, 1'b0, 1'b1});
    tick();
    rst_n = 1'b1;
    tick();
    send_exp("post_rst_in", 0, 1, rnd(), rnd());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
